// File: rtl/coyote_qdma_pkg.sv
// Shared types, widths and beat-analysis helpers for the QDMA C2H framer.
package coyote_qdma_pkg;

   localparam int DATA_BYTES = 64;
   localparam int DATA_W     = 8 * DATA_BYTES;
   localparam int MTY_W      = $clog2(DATA_BYTES);
   localparam int CNT_W      = MTY_W + 1;   // holds 0..DATA_BYTES
   localparam int LEN_W      = 16;
   localparam int QID_W      = 11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      CMPT   = 2'd2
   } state_t;

   typedef struct packed {
      logic [LEN_W-1:0] len;
      logic [QID_W-1:0] qid;
      logic             err;
   } cmpt_t;

   // Number of enabled bytes in a beat.
   function automatic logic [CNT_W-1:0] keep_popcount(input logic [DATA_BYTES-1:0] keep);
      logic [CNT_W-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < DATA_BYTES; i++) begin
         cnt = cnt + {{(CNT_W-1){1'b0}}, keep[i]};
      end
      return cnt;
   endfunction

   // True when keep is of the form 0..01..1 (ones packed from the LSB, or all zero).
   // Adding one to such a pattern carries through every set bit, so the AND is zero.
   function automatic logic keep_contiguous(input logic [DATA_BYTES-1:0] keep);
      logic [DATA_BYTES-1:0] plus_one;
      plus_one = keep + {{(DATA_BYTES-1){1'b0}}, 1'b1};
      return ((keep & plus_one) == '0);
   endfunction

endpackage

// File: rtl/coyote_axis_skid.sv
// Two-entry register slice: one-cycle latency, full throughput, and the
// output register never changes while valid is held without a handshake.
module coyote_axis_skid
   import coyote_qdma_pkg::*;
#(
   parameter int PAYLOAD_W = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [PAYLOAD_W-1:0] in_payload_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [PAYLOAD_W-1:0] out_payload_o
);

   logic                 main_valid_q, main_valid_d;
   logic                 skid_valid_q, skid_valid_d;
   logic [PAYLOAD_W-1:0] main_q, main_d;
   logic [PAYLOAD_W-1:0] skid_q, skid_d;
   logic                 in_fire_s;
   logic                 main_free_s;

   // The slice accepts input as long as the overflow entry is empty.
   assign in_ready_o    = ~skid_valid_q;
   assign in_fire_s     = in_valid_i & ~skid_valid_q;
   assign main_free_s   = ~main_valid_q | out_ready_i;
   assign out_valid_o   = main_valid_q;
   assign out_payload_o = main_q;

   // Next-state: refill the output entry from overflow first, then from input;
   // park an input beat in overflow when the output entry is stalled.
   always_comb begin
      main_valid_d = main_valid_q;
      main_d       = main_q;
      skid_valid_d = skid_valid_q;
      skid_d       = skid_q;
      if (main_free_s) begin
         if (skid_valid_q) begin
            main_valid_d = 1'b1;
            main_d       = skid_q;
            skid_valid_d = 1'b0;
         end else if (in_fire_s) begin
            main_valid_d = 1'b1;
            main_d       = in_payload_i;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (in_fire_s) begin
         skid_valid_d = 1'b1;
         skid_d       = in_payload_i;
      end else begin
         skid_valid_d = skid_valid_q;
      end
   end

   // Slice registers with synchronous reset; reset empties both entries.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         main_q       <= '0;
         skid_q       <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         main_q       <= main_d;
         skid_q       <= skid_d;
      end
   end

endmodule

// File: rtl/coyote_qdma_c2h_framer.sv
// Frames a tkeep-annotated AXI-Stream into the QDMA C2H stream and issues one
// completion per packet, flagging length mismatches and malformed tkeep.
module coyote_qdma_c2h_framer
   import coyote_qdma_pkg::*;
(
   input  logic                  aclk_i,
   input  logic                  areset_i,
   input  logic                  s_desc_valid_i,
   output logic                  s_desc_ready_o,
   input  logic [LEN_W-1:0]      s_desc_len_i,
   input  logic [QID_W-1:0]      s_desc_qid_i,
   input  logic                  s_axis_tvalid_i,
   output logic                  s_axis_tready_o,
   input  logic [DATA_W-1:0]     s_axis_tdata_i,
   input  logic [DATA_BYTES-1:0] s_axis_tkeep_i,
   input  logic                  s_axis_tlast_i,
   output logic                  m_c2h_valid_o,
   input  logic                  m_c2h_ready_i,
   output logic [DATA_W-1:0]     m_c2h_data_o,
   output logic [MTY_W-1:0]      m_c2h_mty_o,
   output logic                  m_c2h_last_o,
   output logic [LEN_W-1:0]      m_c2h_ctrl_len_o,
   output logic [QID_W-1:0]      m_c2h_ctrl_qid_o,
   output logic                  m_cmpt_valid_o,
   input  logic                  m_cmpt_ready_i,
   output logic [LEN_W-1:0]      m_cmpt_len_o,
   output logic [QID_W-1:0]      m_cmpt_qid_o,
   output logic                  m_cmpt_err_o,
   output logic [31:0]           pkt_count_o,
   output logic [31:0]           err_count_o
);

   localparam int SKID_W = DATA_W + MTY_W + 1;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [QID_W-1:0] qid_q, qid_d;
   logic [LEN_W-1:0] acc_q, acc_d;
   logic             err_q, err_d;
   logic             last_in_q, last_in_d;   // last beat already taken at input
   logic [31:0]      pkt_count_q, pkt_count_d;
   logic [31:0]      err_count_q, err_count_d;

   logic             desc_fire_s;
   logic             stream_open_s;
   logic             skid_in_valid_s;
   logic             skid_in_ready_s;
   logic             beat_fire_s;
   logic             c2h_last_fire_s;
   logic             cmpt_fire_s;
   logic [CNT_W-1:0] beat_cnt_s;
   logic [CNT_W-1:0] mty_full_s;
   logic [MTY_W-1:0] mty_s;
   logic [LEN_W:0]   acc_sum_s;
   logic [LEN_W-1:0] acc_next_s;
   logic             keep_full_s;
   logic             keep_zero_s;
   logic             beat_err_s;
   logic [SKID_W-1:0] skid_in_payload_s;
   logic [SKID_W-1:0] skid_out_payload_s;
   cmpt_t            cmpt_s;

   // Handshake qualifiers; reset holds every ready low.
   assign s_desc_ready_o  = (state_q == IDLE) & ~areset_i;
   assign desc_fire_s     = s_desc_valid_i & s_desc_ready_o;
   assign stream_open_s   = (state_q == STREAM) & ~last_in_q & ~areset_i;
   assign skid_in_valid_s = s_axis_tvalid_i & stream_open_s;
   assign s_axis_tready_o = stream_open_s & skid_in_ready_s;
   assign beat_fire_s     = s_axis_tvalid_i & s_axis_tready_o;
   assign c2h_last_fire_s = m_c2h_valid_o & m_c2h_ready_i & m_c2h_last_o;
   assign m_cmpt_valid_o  = (state_q == CMPT);
   assign cmpt_fire_s     = m_cmpt_valid_o & m_cmpt_ready_i;

   // Per-beat byte accounting and tkeep sanity checks.
   assign beat_cnt_s  = keep_popcount(s_axis_tkeep_i);
   assign keep_full_s = &s_axis_tkeep_i;
   assign keep_zero_s = ~|s_axis_tkeep_i;
   assign acc_sum_s   = {1'b0, acc_q} + {{(LEN_W+1-CNT_W){1'b0}}, beat_cnt_s};
   assign acc_next_s  = acc_sum_s[LEN_W] ? {LEN_W{1'b1}} : acc_sum_s[LEN_W-1:0];
   assign beat_err_s  = (~s_axis_tlast_i & ~keep_full_s)
                      | ~keep_contiguous(s_axis_tkeep_i)
                      | (s_axis_tlast_i & keep_zero_s);
   assign mty_full_s  = CNT_W'(DATA_BYTES) - beat_cnt_s;

   // Empty-byte count is only meaningful on a non-empty last beat.
   always_comb begin
      mty_s = '0;
      if (s_axis_tlast_i && !keep_zero_s) begin
         mty_s = mty_full_s[MTY_W-1:0];
      end else begin
         mty_s = '0;
      end
   end

   assign skid_in_payload_s = {s_axis_tdata_i, mty_s, s_axis_tlast_i};

   coyote_axis_skid #(
      .PAYLOAD_W (SKID_W)
   ) u_skid (
      .clk_i         (aclk_i),
      .rst_i         (areset_i),
      .in_valid_i    (skid_in_valid_s),
      .in_ready_o    (skid_in_ready_s),
      .in_payload_i  (skid_in_payload_s),
      .out_valid_o   (m_c2h_valid_o),
      .out_ready_i   (m_c2h_ready_i),
      .out_payload_o (skid_out_payload_s)
   );

   assign m_c2h_data_o = skid_out_payload_s[SKID_W-1 -: DATA_W];
   assign m_c2h_mty_o  = skid_out_payload_s[MTY_W:1];
   assign m_c2h_last_o = skid_out_payload_s[0];

   // Descriptor fields are latched once per packet, so ctrl stays constant.
   assign m_c2h_ctrl_len_o = len_q;
   assign m_c2h_ctrl_qid_o = qid_q;

   assign cmpt_s.len   = acc_q;
   assign cmpt_s.qid   = qid_q;
   assign cmpt_s.err   = err_q;
   assign m_cmpt_len_o = cmpt_s.len;
   assign m_cmpt_qid_o = cmpt_s.qid;
   assign m_cmpt_err_o = cmpt_s.err;

   assign pkt_count_o = pkt_count_q;
   assign err_count_o = err_count_q;

   // Packet FSM next-state: descriptor latch, beat accumulation, completion.
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      qid_d       = qid_q;
      acc_d       = acc_q;
      err_d       = err_q;
      last_in_d   = last_in_q;
      pkt_count_d = pkt_count_q;
      err_count_d = err_count_q;
      case (state_q)
         IDLE: begin
            if (desc_fire_s) begin
               len_d     = s_desc_len_i;
               qid_d     = s_desc_qid_i;
               acc_d     = '0;
               last_in_d = 1'b0;
               if (s_desc_len_i == '0) begin
                  err_d   = 1'b1;
                  state_d = CMPT;
               end else begin
                  err_d   = 1'b0;
                  state_d = STREAM;
               end
            end else begin
               state_d = IDLE;
            end
         end
         STREAM: begin
            if (beat_fire_s) begin
               acc_d     = acc_next_s;
               err_d     = err_q | beat_err_s | (s_axis_tlast_i & (acc_next_s != len_q));
               last_in_d = s_axis_tlast_i;
            end else begin
               acc_d = acc_q;
            end
            // Completion waits until the final beat has left the slice.
            if (c2h_last_fire_s) begin
               state_d   = CMPT;
               last_in_d = 1'b0;
            end else begin
               state_d = STREAM;
            end
         end
         CMPT: begin
            if (cmpt_fire_s) begin
               pkt_count_d = pkt_count_q + 32'd1;
               err_count_d = err_count_q + {31'd0, err_q};
               state_d     = IDLE;
            end else begin
               state_d = CMPT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Packet FSM registers; reset drops any partial packet without a completion.
   always_ff @(posedge aclk_i) begin
      if (areset_i) begin
         state_q     <= IDLE;
         len_q       <= '0;
         qid_q       <= '0;
         acc_q       <= '0;
         err_q       <= 1'b0;
         last_in_q   <= 1'b0;
         pkt_count_q <= 32'd0;
         err_count_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         qid_q       <= qid_d;
         acc_q       <= acc_d;
         err_q       <= err_d;
         last_in_q   <= last_in_d;
         pkt_count_q <= pkt_count_d;
         err_count_q <= err_count_d;
      end
   end

endmodule

// File: tb/tb_coyote_qdma_c2h_framer.sv
// Directed self-checking bench for coyote_qdma_c2h_framer.
module tb_coyote_qdma_c2h_framer;
   import coyote_qdma_pkg::*;

   logic                  clk;
   logic                  areset;
   logic                  desc_valid, desc_ready;
   logic [LEN_W-1:0]      desc_len;
   logic [QID_W-1:0]      desc_qid;
   logic                  tvalid, tready;
   logic [DATA_W-1:0]     tdata;
   logic [DATA_BYTES-1:0] tkeep;
   logic                  tlast;
   logic                  c2h_valid, c2h_ready;
   logic [DATA_W-1:0]     c2h_data;
   logic [MTY_W-1:0]      c2h_mty;
   logic                  c2h_last;
   logic [LEN_W-1:0]      c2h_ctrl_len;
   logic [QID_W-1:0]      c2h_ctrl_qid;
   logic                  cmpt_valid, cmpt_ready;
   logic [LEN_W-1:0]      cmpt_len;
   logic [QID_W-1:0]      cmpt_qid;
   logic                  cmpt_err;
   logic [31:0]           pkt_count, err_count;

   int checks   = 0;
   int failures = 0;

   logic [DATA_BYTES-1:0] keep_a [4];
   logic [MTY_W-1:0]      mty_a  [4];
   logic [31:0]           seed;
   logic [DATA_BYTES-1:0] all_ones;

   coyote_qdma_c2h_framer dut (
      .aclk_i           (clk),
      .areset_i         (areset),
      .s_desc_valid_i   (desc_valid),
      .s_desc_ready_o   (desc_ready),
      .s_desc_len_i     (desc_len),
      .s_desc_qid_i     (desc_qid),
      .s_axis_tvalid_i  (tvalid),
      .s_axis_tready_o  (tready),
      .s_axis_tdata_i   (tdata),
      .s_axis_tkeep_i   (tkeep),
      .s_axis_tlast_i   (tlast),
      .m_c2h_valid_o    (c2h_valid),
      .m_c2h_ready_i    (c2h_ready),
      .m_c2h_data_o     (c2h_data),
      .m_c2h_mty_o      (c2h_mty),
      .m_c2h_last_o     (c2h_last),
      .m_c2h_ctrl_len_o (c2h_ctrl_len),
      .m_c2h_ctrl_qid_o (c2h_ctrl_qid),
      .m_cmpt_valid_o   (cmpt_valid),
      .m_cmpt_ready_i   (cmpt_ready),
      .m_cmpt_len_o     (cmpt_len),
      .m_cmpt_qid_o     (cmpt_qid),
      .m_cmpt_err_o     (cmpt_err),
      .pkt_count_o      (pkt_count),
      .err_count_o      (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   function automatic logic [DATA_W-1:0] mkdata(input logic [31:0] s);
      logic [DATA_W-1:0] d;
      for (int i = 0; i < DATA_W/32; i++) begin
         d[i*32 +: 32] = (s * 32'h9E37_79B9) ^ 32'(i);
      end
      return d;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_data(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_desc(input logic [LEN_W-1:0] len, input logic [QID_W-1:0] qid);
      int w;
      desc_valid = 1'b1;
      desc_len   = len;
      desc_qid   = qid;
      #1;
      w = 0;
      while (!desc_ready && w < 50) begin
         @(negedge clk); #1; w++;
      end
      chk("desc_ready", 64'(desc_ready), 64'd1);
      @(negedge clk);
      desc_valid = 1'b0;
   endtask

   // Drives n beats from keep_a/mkdata and checks every output handshake in order.
   task automatic run_pkt(input int n, input bit rnd, input logic [LEN_W-1:0] clen,
                          input logic [QID_W-1:0] cqid);
      int in_idx, out_idx, last_in_cyc;
      logic prev_hold;
      logic [DATA_W-1:0] prev_data;
      in_idx = 0; out_idx = 0; last_in_cyc = -1; prev_hold = 1'b0; prev_data = '0;
      for (int cyc = 0; cyc < 400 && out_idx < n; cyc++) begin
         if (in_idx < n) begin
            tvalid = 1'b1;
            tdata  = mkdata(seed + 32'(in_idx));
            tkeep  = keep_a[in_idx];
            tlast  = (in_idx == n - 1);
         end else begin
            tvalid = 1'b0; tdata = '0; tkeep = '0; tlast = 1'b0;
         end
         c2h_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (prev_hold) begin
            chk("c2h_hold_valid", 64'(c2h_valid), 64'd1);
            chk_data("c2h_hold_data", c2h_data, prev_data);
         end
         if (c2h_valid && c2h_ready) begin
            chk_data("c2h_data", c2h_data, mkdata(seed + 32'(out_idx)));
            chk("c2h_mty", 64'(c2h_mty), 64'(mty_a[out_idx]));
            chk("c2h_last", 64'(c2h_last), 64'(out_idx == n - 1));
            chk("c2h_ctrl_len", 64'(c2h_ctrl_len), 64'(clen));
            chk("c2h_ctrl_qid", 64'(c2h_ctrl_qid), 64'(cqid));
            out_idx++;
         end
         prev_hold = c2h_valid & ~c2h_ready;
         prev_data = c2h_data;
         if (tvalid && tready) begin
            last_in_cyc = cyc;
            in_idx++;
         end
         @(negedge clk);
      end
      tvalid = 1'b0; tkeep = '0; tlast = 1'b0;
      chk("pkt_out_beats", 64'(out_idx), 64'(n));
      if (!rnd) chk("full_rate_last_in_cycle", 64'(last_in_cyc), 64'(n - 1));
   endtask

   task automatic wait_cmpt(input logic [LEN_W-1:0] elen, input logic [QID_W-1:0] eqid,
                            input logic eerr, input logic [31:0] epkt, input logic [31:0] eerrc);
      int w;
      #1;
      w = 0;
      while (!cmpt_valid && w < 50) begin
         @(negedge clk); #1; w++;
      end
      chk("cmpt_valid", 64'(cmpt_valid), 64'd1);
      chk("cmpt_len", 64'(cmpt_len), 64'(elen));
      chk("cmpt_qid", 64'(cmpt_qid), 64'(eqid));
      chk("cmpt_err", 64'(cmpt_err), 64'(eerr));
      chk("tready_in_cmpt", 64'(tready), 64'd0);
      cmpt_ready = 1'b1;
      @(negedge clk);
      cmpt_ready = 1'b0;
      #1;
      chk("cmpt_valid_after_hs", 64'(cmpt_valid), 64'd0);
      chk("pkt_count", 64'(pkt_count), 64'(epkt));
      chk("err_count", 64'(err_count), 64'(eerrc));
      @(negedge clk);
   endtask

   initial begin
      all_ones   = '1;
      areset     = 1'b1;
      desc_valid = 1'b0; desc_len = '0; desc_qid = '0;
      tvalid = 1'b0; tdata = '0; tkeep = '0; tlast = 1'b0;
      c2h_ready = 1'b0; cmpt_ready = 1'b0;
      seed = 32'd0;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_desc_ready", 64'(desc_ready), 64'd0);
      chk("rst_tready", 64'(tready), 64'd0);
      chk("rst_c2h_valid", 64'(c2h_valid), 64'd0);
      chk("rst_cmpt_valid", 64'(cmpt_valid), 64'd0);
      chk("rst_pkt_count", 64'(pkt_count), 64'd0);
      chk("rst_err_count", 64'(err_count), 64'd0);
      @(negedge clk);
      areset = 1'b0;
      #1;
      chk("post_rst_desc_ready", 64'(desc_ready), 64'd1);
      @(negedge clk);

      // Single beat: 10 bytes -> mty 54
      seed = 32'd100; keep_a[0] = 64'h3FF; mty_a[0] = 6'd54;
      send_desc(16'd10, 11'd3);
      run_pkt(1, 1'b0, 16'd10, 11'd3);
      wait_cmpt(16'd10, 11'd3, 1'b0, 32'd1, 32'd0);

      // Multi-beat: 64+64+64+8 = 200
      seed = 32'd200;
      keep_a[0] = all_ones; keep_a[1] = all_ones; keep_a[2] = all_ones; keep_a[3] = 64'hFF;
      mty_a[0] = 6'd0; mty_a[1] = 6'd0; mty_a[2] = 6'd0; mty_a[3] = 6'd56;
      send_desc(16'd200, 11'd9);
      run_pkt(4, 1'b0, 16'd200, 11'd9);
      wait_cmpt(16'd200, 11'd9, 1'b0, 32'd2, 32'd0);

      // Length mismatch: 100 expected, 64 delivered
      seed = 32'd300; keep_a[0] = all_ones; mty_a[0] = 6'd0;
      send_desc(16'd100, 11'd17);
      run_pkt(1, 1'b0, 16'd100, 11'd17);
      wait_cmpt(16'd64, 11'd17, 1'b1, 32'd3, 32'd1);

      // Backpressure: 64+64+2 = 130, random c2h ready, completion held 20 cycles
      seed = 32'd400;
      keep_a[0] = all_ones; keep_a[1] = all_ones; keep_a[2] = 64'h3;
      mty_a[0] = 6'd0; mty_a[1] = 6'd0; mty_a[2] = 6'd62;
      send_desc(16'd130, 11'd1023);
      run_pkt(3, 1'b1, 16'd130, 11'd1023);
      desc_valid = 1'b1; desc_len = 16'd0; desc_qid = 11'd5;
      cmpt_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         #1;
         chk("bp_cmpt_valid_held", 64'(cmpt_valid), 64'd1);
         chk("bp_cmpt_len_held", 64'(cmpt_len), 64'd130);
         chk("bp_cmpt_err_held", 64'(cmpt_err), 64'd0);
         chk("bp_desc_blocked", 64'(desc_ready), 64'd0);
         @(negedge clk);
      end
      cmpt_ready = 1'b1;
      @(negedge clk);
      cmpt_ready = 1'b0;
      #1;
      chk("bp_pkt_count", 64'(pkt_count), 64'd4);
      chk("bp_err_count", 64'(err_count), 64'd1);
      chk("desc_ready_after_cmpt", 64'(desc_ready), 64'd1);

      // Zero-length descriptor accepted next: immediate completion, no data
      @(negedge clk);
      desc_valid = 1'b0;
      #1;
      chk("zl_cmpt_valid", 64'(cmpt_valid), 64'd1);
      chk("zl_tready", 64'(tready), 64'd0);
      chk("zl_c2h_valid", 64'(c2h_valid), 64'd0);
      wait_cmpt(16'd0, 11'd5, 1'b1, 32'd5, 32'd2);

      // Bad tkeep on a non-last beat: 32 + 64 = 96 counted
      seed = 32'd500;
      keep_a[0] = {8{8'h0F}}; keep_a[1] = all_ones;
      mty_a[0] = 6'd0; mty_a[1] = 6'd0;
      send_desc(16'd128, 11'd2);
      run_pkt(2, 1'b0, 16'd128, 11'd2);
      wait_cmpt(16'd96, 11'd2, 1'b1, 32'd6, 32'd3);

      // Reset mid-packet after two beats
      send_desc(16'd256, 11'd7);
      c2h_ready = 1'b1;
      tvalid = 1'b1; tdata = mkdata(32'd600); tkeep = all_ones; tlast = 1'b0;
      @(negedge clk);
      @(negedge clk);
      tvalid = 1'b0; tkeep = '0;
      areset = 1'b1;
      @(negedge clk);
      #1;
      chk("mid_rst_c2h_valid", 64'(c2h_valid), 64'd0);
      chk("mid_rst_cmpt_valid", 64'(cmpt_valid), 64'd0);
      chk("mid_rst_desc_ready", 64'(desc_ready), 64'd0);
      chk("mid_rst_tready", 64'(tready), 64'd0);
      chk("mid_rst_pkt_count", 64'(pkt_count), 64'd0);
      chk("mid_rst_err_count", 64'(err_count), 64'd0);
      @(negedge clk);
      areset = 1'b0;
      #1;
      chk("mid_rst_desc_ready_after", 64'(desc_ready), 64'd1);
      @(negedge clk);
      seed = 32'd700; keep_a[0] = 64'h3FF; mty_a[0] = 6'd54;
      send_desc(16'd10, 11'd4);
      run_pkt(1, 1'b0, 16'd10, 11'd4);
      wait_cmpt(16'd10, 11'd4, 1'b0, 32'd1, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
